ahb_master_arbiter: RTL and testbench

AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

---
 rtl/ahb_pkg.sv | 12 +
 rtl/rr_arb2.sv | 20 ++
 rtl/ahb_master_arbiter.sv | 92 +++++++++
 tb/tb_ahb_master_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings, arbiter FSM states and command legality check
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR} state_t;
  function automatic logic illegal_cmd(input logic [2:0] size, input logic [1:0] lsb);
    return (size > HSIZE_WORD) || (size == HSIZE_WORD && lsb != 2'b00) || (size == HSIZE_HALF && lsb[0]);
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant with last-grant register (resets to 1 so requester 0 wins first)
module rr_arb2 (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic en,
  input  logic v0,
  input  logic v1,
  output logic gnt0,
  output logic gnt1
);
  logic last;
  always_comb begin
    gnt0 = en & v0 & (~v1 | last);
    gnt1 = en & v1 & (~v0 | ~last);
  end
  always_ff @(posedge HCLK) begin
    if (!HRESETn) last <= 1'b1;
    else if (gnt0 | gnt1) last <= gnt1;
  end
endmodule

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: two requesters arbitrated onto one AHB-Lite master port, one transfer at a time
module ahb_master_arbiter import ahb_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic        req0_write,
  input  logic        req1_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req0_wdata,
  input  logic [31:0] req1_wdata,
  input  logic [2:0]  req0_size,
  input  logic [2:0]  req1_size,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA
);
  localparam int CW = TIMEOUT_CYCLES < 2 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_nx;
  logic gnt0, gnt1, take, bad, done, tmo;
  logic [31:0] c_addr, wdata_q;
  logic [2:0] c_size;
  logic id_q;
  logic [CW-1:0] cnt;
  rr_arb2 u_arb (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .en(state == ST_IDLE && HRESETn),
    .v0(req0_valid),
    .v1(req1_valid),
    .gnt0(gnt0),
    .gnt1(gnt1)
  );
  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    take = gnt0 | gnt1;
    c_addr = gnt1 ? req1_addr : req0_addr;
    c_size = gnt1 ? req1_size : req0_size;
    bad = illegal_cmd(c_size, c_addr[1:0]);
    done = state == ST_DATA && HREADY;
    // timeout fires on the stalled cycle that brings the count to TIMEOUT_CYCLES
    tmo = TIMEOUT_CYCLES != 0 && state == ST_DATA && !HREADY && cnt == CW'(TIMEOUT_CYCLES - 1);
    state_nx = take ? (bad ? ST_ERR : ST_ADDR) :
               (state == ST_ADDR && HREADY) ? ST_DATA :
               (done || tmo || state == ST_ERR) ? ST_IDLE : state;
    HTRANS = state == ST_ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
    HWDATA = (state == ST_DATA && HWRITE) ? wdata_q : '0;
  end
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      HADDR <= '0;
      HWRITE <= 1'b0;
      HSIZE <= HSIZE_BYTE;
      wdata_q <= '0;
      id_q <= 1'b0;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_id <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nx;
      rsp_valid <= done || tmo || state == ST_ERR;
      rsp_err <= tmo || state == ST_ERR;
      rsp_id <= id_q;
      rsp_rdata <= (done && !HWRITE) ? HRDATA : '0;
      cnt <= state == ST_ADDR ? '0 : (state == ST_DATA && !HREADY && cnt != '1) ? cnt + 1'b1 : cnt;
      if (take) begin
        HADDR <= c_addr;
        HSIZE <= c_size;
        HWRITE <= gnt1 ? req1_write : req0_write;
        wdata_q <= gnt1 ? req1_wdata : req0_wdata;
        id_q <= gnt1;
      end
    end
  end
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter: directed and randomized checks against a transaction-level reference model
module tb_ahb_master_arbiter;
  localparam int TMO = 16;
  logic HCLK = 1'b0;
  logic HRESETn;
  logic req0_valid, req1_valid, req0_ready, req1_ready, req0_write, req1_write;
  logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
  logic [2:0] req0_size, req1_size;
  logic rsp_valid, rsp_id, rsp_err;
  logic [31:0] rsp_rdata, HADDR, HWDATA, HRDATA;
  logic [1:0] HTRANS;
  logic HWRITE, HREADY;
  logic [2:0] HSIZE;
  int checks = 0;
  int failures = 0;
  bit model_last = 1'b1;
  always #5 HCLK = ~HCLK;
  ahb_master_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_write(req0_write), .req1_write(req1_write),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .req0_size(req0_size), .req1_size(req1_size),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask
  task automatic samp();
    @(negedge HCLK);
  endtask
  task automatic set_req(input bit id, input bit v, input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] sz);
    if (id) begin
      req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = wd; req1_size = sz;
    end else begin
      req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = wd; req0_size = sz;
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_htrans"}, HTRANS, 0);
    chk({tag, "_haddr"}, HADDR, 0);
    chk({tag, "_hwrite"}, HWRITE, 0);
    chk({tag, "_hsize"}, HSIZE, 0);
    chk({tag, "_hwdata"}, HWDATA, 0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_id}, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_ready"}, {req1_ready, req0_ready}, 0);
  endtask
  // One lone-requester command; expected latency and response come from the transaction rules.
  task automatic run_cmd(input bit id, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] sz, input int stall, input logic [31:0] rd, input bit ghost);
    bit bad, tmo;
    int lat;
    bad = (sz > 3'd2) || (sz == 3'd2 && a[1:0] != 2'b00) || (sz == 3'd1 && a[0]);
    tmo = !bad && stall >= TMO;
    lat = bad ? 2 : tmo ? 2 + TMO : 3 + stall;
    tick();
    set_req(id, 1'b1, wr, a, wd, sz);
    set_req(!id, 1'b0, 1'($urandom), $urandom, $urandom, 3'($urandom));
    HREADY = 1'b1;
    samp();
    chk("handshake_ready", {req1_ready, req0_ready}, id ? 2 : 1);
    model_last = id;
    for (int k = 1; k <= lat + 1; k++) begin
      tick();
      if (id) begin req1_valid = 1'b0; req0_valid = ghost && k == 1; end
      else begin req0_valid = 1'b0; req1_valid = ghost && k == 1; end
      HREADY = !(k >= 2 && k < 2 + stall);
      HRDATA = (k == 2 + stall) ? rd : $urandom;
      samp();
      chk("ready_busy", {req1_ready, req0_ready}, 0);
      chk("htrans", HTRANS, (k == 1 && !bad) ? 2 : 0);
      if (k == 1 && !bad) begin
        chk("haddr", HADDR, a);
        chk("hwrite_hsize", {HWRITE, HSIZE}, {wr, sz});
      end
      if (k == 2 && !bad) chk("hwdata", HWDATA, wr ? wd : 0);
      chk("rsp_valid_timing", rsp_valid, k == lat);
      if (k == lat) begin
        chk("rsp_id", rsp_id, id);
        chk("rsp_err", rsp_err, bad || tmo);
        chk("rsp_rdata", rsp_rdata, (bad || tmo || wr) ? 0 : rd);
      end
    end
  endtask
  initial begin
    int grants[$];
    int rsps[$];
    bit exp_w;
    HRESETn = 1'b0;
    set_req(0, 1'b1, 1'b1, 32'h4, 32'h1, 3'd2);
    set_req(1, 1'b0, 1'b0, 0, 0, 3'd0);
    HREADY = 1'b1;
    HRDATA = 0;
    tick();
    tick();
    samp();
    chk_reset_outputs("reset");
    tick();
    HRESETn = 1'b1;
    req0_valid = 1'b0;
    run_cmd(0, 1'b1, 32'h1, 32'hFFFFFFFF, 3'd0, 0, 0, 0);
    run_cmd(1, 1'b0, 32'h10, 0, 3'd2, 3, 32'hF, 0);
    run_cmd(0, 1'b1, 32'h2, 32'h1234, 3'd2, 0, 0, 0);
    run_cmd(1, 1'b0, 32'h3, 0, 3'd1, 0, 0, 0);
    run_cmd(0, 1'b0, 32'h20, 0, 3'd3, 0, 0, 0);
    run_cmd(1, 1'b0, 32'h100, 0, 3'd2, 20, 32'h55, 0);
    run_cmd(0, 1'b0, 32'h104, 0, 3'd2, TMO, 32'h66, 0);
    run_cmd(1, 1'b0, 32'h108, 0, 3'd2, TMO - 1, 32'h77, 0);
    run_cmd(0, 1'b1, 32'h8, 32'hA5, 3'd1, 1, 0, 1);
    // reset while the write sits in its data phase
    tick();
    set_req(0, 1'b1, 1'b1, 32'h40, 32'hCAFE, 3'd2);
    tick();
    req0_valid = 1'b0;
    tick();
    HREADY = 1'b0;
    samp();
    chk("mid_hwdata", HWDATA, 32'hCAFE);
    tick();
    HRESETn = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    samp();
    chk("mid_ready_in_reset", {req1_ready, req0_ready}, 0);
    tick();
    samp();
    chk_reset_outputs("mid_reset");
    tick();
    HRESETn = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    HREADY = 1'b1;
    model_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      samp();
      chk("post_reset_quiet", {rsp_valid, HTRANS}, 0);
      tick();
    end
    // both requesters held valid for four commands
    set_req(0, 1'b1, 1'b1, 32'h100, 32'h11, 3'd2);
    set_req(1, 1'b1, 1'b0, 32'h200, 0, 3'd2);
    for (int c = 0; c < 40 && rsps.size() < 4; c++) begin
      samp();
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp_valid) rsps.push_back(int'(rsp_id));
      tick();
      if (grants.size() >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    chk("cont_grant_count", grants.size(), 4);
    chk("cont_rsp_count", rsps.size(), 4);
    exp_w = !model_last;
    for (int i = 0; i < grants.size(); i++) begin
      chk("cont_grant_order", grants[i], exp_w);
      if (i < rsps.size()) chk("cont_rsp_order", rsps[i], exp_w);
      model_last = exp_w;
      exp_w = !exp_w;
    end
    for (int n = 0; n < 30; n++) begin
      bit id, wr;
      logic [31:0] a;
      logic [2:0] sz;
      int stall;
      id = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      stall = ($urandom_range(0, 9) == 0) ? TMO + int'($urandom_range(0, 2)) : int'($urandom_range(0, 4));
      run_cmd(id, wr, a, $urandom, sz, stall, $urandom, 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
